id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-002 SHALL have inputs: id_valid 1, decode slot valid; id_pc 32; id_rs1_addr/id_rs2_addr/id_rd_addr 5 each; id_rs1_data/id_rs2_data/id_imm32 32 each.
REQ-003 SHALL have decode control inputs: id_alu_opt 5; id_alu_a_sel 1 (1=pc); id_alu_b_sel 2 (00 rs2, 01 imm, 11 const 4); id_write_reg_enable 1; id_write_ram_flag 2; id_wb_sel 1 (1=memory); id_load_ram_flag 3; id_pc_condition 2.
REQ-004 SHALL have inputs: ex_flush 1, kill EX slot (branch/jump redirect); ex_stall 1, downstream hold.
REQ-005 SHALL have outputs: ex_valid 1 plus an ex_ copy of every REQ-002/REQ-003 field except id_valid, same widths, all registered.
REQ-006 SHALL have output hazard_stall 1, combinational, instructs IF and IF/ID to hold.
REQ-007 SHALL have output bubble_count 32 when ID_EX_PERF_EN is defined.

Function
REQ-008 Per rising edge, priority SHALL be: ex_flush > ex_stall > load-use bubble > normal load.
REQ-009 Normal load: all ex_ fields take id_ values; ex_valid <= id_valid; latency one cycle.
REQ-010 Flush or bubble: ex_valid <= 0; ex_write_reg_enable, ex_write_ram_flag, ex_load_ram_flag, ex_pc_condition, ex_wb_sel <= 0; datapath fields don't-care but SHALL be zeroed.
REQ-011 ex_stall without ex_flush: every ex_ register holds its value.
REQ-012 rs1_used = id_alu_a_sel==0 and id_alu_opt!=5'b10001; rs2_used = id_alu_b_sel==00 or id_write_ram_flag!=00.
REQ-013 load_use = id_valid & ex_valid & ex_wb_sel & ex_write_reg_enable & ex_rd_addr!=0 & ((rs1_used & id_rs1_addr==ex_rd_addr) | (rs2_used & id_rs2_addr==ex_rd_addr)).
REQ-014 hazard_stall = (load_use | ex_stall) & ~ex_flush.
REQ-015 Load-use inserts exactly one bubble; next cycle EX holds bubble, load_use drops, ID instruction loads normally.
REQ-016 Back-to-back dependent loads: each dependency produces its own single bubble.
REQ-017 ex_flush concurrent with load_use or ex_stall: flush wins, hazard_stall=0, no bubble counted.
REQ-018 rd_addr==0 in EX SHALL never cause a stall.

Reset
REQ-019 rst_n low SHALL immediately clear every ex_ output and ex_valid to 0 regardless of clk.
REQ-020 Reset mid-stall SHALL drop hazard_stall within the same cycle (ex_valid=0 forces load_use=0, absent ex_stall).
REQ-021 First edge after rst_n release SHALL perform a normal load.

Configuration
REQ-022 Macro ID_EX_PERF_EN: defined -> bubble_count present, reset 0, +1 on each edge where a load-use bubble is inserted, saturates at 32'hFFFF_FFFF; undefined -> port and counter absent, all other behaviour identical.

Verification
REQ-023 lw x5 in EX (ex_wb_sel=1, rd=5), ID add x6,x5,x1 -> hazard_stall=1, next edge ex_valid=0, following edge ex_rd_addr=6, ex_valid=1; bubble_count=1.
REQ-024 lw x0 in EX, ID uses x0 -> hazard_stall=0, no bubble.
REQ-025 lw x5 in EX, ID lui x5 (alu_opt 10001, rs1 field 5) -> no stall; ID sw x5 as rs2 -> stall.
REQ-026 ex_flush=1 with load_use true -> hazard_stall=0, ex_valid=0 next edge, bubble_count unchanged.
REQ-027 ex_stall=1 for 3 cycles with id_pc changing -> ex_pc constant, hazard_stall=1 throughout.
REQ-028 rst_n asserted between edges with ex_valid=1 -> ex_valid and all ex_ outputs 0 before next edge.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush and stall handling.
// Optional macro ID_EX_PERF_EN adds a saturating bubble_count performance counter.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic [4:0]  id_rd_addr,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_imm32,
  input  logic [4:0]  id_alu_opt,
  input  logic        id_alu_a_sel,
  input  logic [1:0]  id_alu_b_sel,
  input  logic        id_write_reg_enable,
  input  logic [1:0]  id_write_ram_flag,
  input  logic        id_wb_sel,
  input  logic [2:0]  id_load_ram_flag,
  input  logic [1:0]  id_pc_condition,
  input  logic        ex_flush,
  input  logic        ex_stall,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [4:0]  ex_rs1_addr,
  output logic [4:0]  ex_rs2_addr,
  output logic [4:0]  ex_rd_addr,
  output logic [31:0] ex_rs1_data,
  output logic [31:0] ex_rs2_data,
  output logic [31:0] ex_imm32,
  output logic [4:0]  ex_alu_opt,
  output logic        ex_alu_a_sel,
  output logic [1:0]  ex_alu_b_sel,
  output logic        ex_write_reg_enable,
  output logic [1:0]  ex_write_ram_flag,
  output logic        ex_wb_sel,
  output logic [2:0]  ex_load_ram_flag,
  output logic [1:0]  ex_pc_condition,
  output logic        hazard_stall
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0] bubble_count
`endif
);

  localparam int SLOT_W = 161;
  localparam logic [4:0] OPT_LUI = 5'b10001;

  logic [SLOT_W-1:0] id_bus;
  logic [SLOT_W-1:0] ex_bus;
  logic              rs1_used;
  logic              rs2_used;
  logic              load_use;
  logic              kill;
  logic              bubble;

  assign id_bus = {id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rd_addr,
                   id_rs1_data, id_rs2_data, id_imm32, id_alu_opt, id_alu_a_sel,
                   id_alu_b_sel, id_write_reg_enable, id_write_ram_flag, id_wb_sel,
                   id_load_ram_flag, id_pc_condition};

  assign {ex_valid, ex_pc, ex_rs1_addr, ex_rs2_addr, ex_rd_addr,
          ex_rs1_data, ex_rs2_data, ex_imm32, ex_alu_opt, ex_alu_a_sel,
          ex_alu_b_sel, ex_write_reg_enable, ex_write_ram_flag, ex_wb_sel,
          ex_load_ram_flag, ex_pc_condition} = ex_bus;

  // lui carries its rd in the rs1 field, so it never reads rs1; stores always read rs2
  assign rs1_used = !id_alu_a_sel && (id_alu_opt != OPT_LUI);
  assign rs2_used = (id_alu_b_sel == 2'b00) || (id_write_ram_flag != 2'b00);

  assign load_use = id_valid && ex_valid && ex_wb_sel && ex_write_reg_enable &&
                    (ex_rd_addr != 5'd0) &&
                    ((rs1_used && (id_rs1_addr == ex_rd_addr)) ||
                     (rs2_used && (id_rs2_addr == ex_rd_addr)));

  assign hazard_stall = (load_use || ex_stall) && !ex_flush;
  assign bubble       = load_use && !ex_stall && !ex_flush;
  assign kill         = ex_flush || bubble;

  // ID -> EX register: flush/bubble zero the whole slot, stall holds it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         ex_bus <= '0;
    else if (kill)      ex_bus <= '0;
    else if (!ex_stall) ex_bus <= id_bus;
  end

`ifdef ID_EX_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      bubble_count <= '0;
    else if (bubble) bubble_count <= sat_inc(bubble_count);
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard scenarios plus randomized
// traffic against a slot-level reference model. Honours ID_EX_PERF_EN.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [4:0]  opt;
    logic        asel;
    logic [1:0]  bsel;
    logic        wre;
    logic [1:0]  wram;
    logic        wb;
    logic [2:0]  ld;
    logic [1:0]  pcc;
  } slot_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  ex_flush = 1'b0;
  logic  ex_stall = 1'b0;
  slot_t id_in = '0;
  slot_t act;
  slot_t exp_ex = '0;
  logic [31:0] exp_bub = '0;
  logic  hazard_stall;
  int    errs = 0;
  int    checks = 0;

  logic        ex_valid, ex_alu_a_sel, ex_write_reg_enable, ex_wb_sel;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm32;
  logic [4:0]  ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_alu_opt;
  logic [1:0]  ex_alu_b_sel, ex_write_ram_flag, ex_pc_condition;
  logic [2:0]  ex_load_ram_flag;
`ifdef ID_EX_PERF_EN
  logic [31:0] bubble_count;
`endif

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_in.valid), .id_pc(id_in.pc),
    .id_rs1_addr(id_in.rs1), .id_rs2_addr(id_in.rs2), .id_rd_addr(id_in.rd),
    .id_rs1_data(id_in.rs1d), .id_rs2_data(id_in.rs2d), .id_imm32(id_in.imm),
    .id_alu_opt(id_in.opt), .id_alu_a_sel(id_in.asel), .id_alu_b_sel(id_in.bsel),
    .id_write_reg_enable(id_in.wre), .id_write_ram_flag(id_in.wram),
    .id_wb_sel(id_in.wb), .id_load_ram_flag(id_in.ld), .id_pc_condition(id_in.pcc),
    .ex_flush(ex_flush), .ex_stall(ex_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm32(ex_imm32),
    .ex_alu_opt(ex_alu_opt), .ex_alu_a_sel(ex_alu_a_sel), .ex_alu_b_sel(ex_alu_b_sel),
    .ex_write_reg_enable(ex_write_reg_enable), .ex_write_ram_flag(ex_write_ram_flag),
    .ex_wb_sel(ex_wb_sel), .ex_load_ram_flag(ex_load_ram_flag),
    .ex_pc_condition(ex_pc_condition),
    .hazard_stall(hazard_stall)
`ifdef ID_EX_PERF_EN
    , .bubble_count(bubble_count)
`endif
  );

  assign act = {ex_valid, ex_pc, ex_rs1_addr, ex_rs2_addr, ex_rd_addr,
                ex_rs1_data, ex_rs2_data, ex_imm32, ex_alu_opt, ex_alu_a_sel,
                ex_alu_b_sel, ex_write_reg_enable, ex_write_ram_flag, ex_wb_sel,
                ex_load_ram_flag, ex_pc_condition};

  // Reference: does the instruction in ID read the register a load in EX is about to write?
  function automatic logic model_lu(slot_t id, slot_t ex);
    logic reads1;
    logic reads2;
    reads1 = (id.asel == 1'b0) && (id.opt != 5'b10001);
    reads2 = (id.bsel == 2'b00) || (id.wram != 2'b00);
    return id.valid && ex.valid && ex.wb && ex.wre && (ex.rd != 5'd0) &&
           ((reads1 && id.rs1 == ex.rd) || (reads2 && id.rs2 == ex.rd));
  endfunction

  function automatic logic model_hz();
    return (model_lu(id_in, exp_ex) || ex_stall) && !ex_flush;
  endfunction

  function automatic slot_t rand_slot();
    slot_t s;
    s.valid = ($urandom_range(0, 9) != 0);
    s.pc    = $urandom;
    s.rs1   = 5'($urandom_range(0, 7));
    s.rs2   = 5'($urandom_range(0, 7));
    s.rd    = 5'($urandom_range(0, 7));
    s.rs1d  = $urandom;
    s.rs2d  = $urandom;
    s.imm   = $urandom;
    s.opt   = ($urandom_range(0, 3) == 0) ? 5'b10001 : 5'($urandom);
    s.asel  = 1'($urandom);
    s.bsel  = 2'($urandom);
    s.wre   = 1'($urandom);
    s.wram  = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
    s.wb    = 1'($urandom);
    s.ld    = 3'($urandom);
    s.pcc   = 2'($urandom);
    return s;
  endfunction

  // Advance the reference model and the DUT by one clock; sample 1ns after the edge
  task automatic tick();
    logic lu;
    lu = model_lu(id_in, exp_ex);
    if (ex_flush) exp_ex = '0;
    else if (ex_stall) exp_ex = exp_ex;
    else if (lu) begin
      exp_ex = '0;
      if (exp_bub != 32'hFFFF_FFFF) exp_bub = exp_bub + 1;
    end else exp_ex = id_in;
    @(posedge clk);
    #1;
  endtask

  function automatic slot_t load_x(input logic [4:0] rd);
    slot_t s;
    s = '0;
    s.valid = 1'b1; s.pc = 32'h100; s.rd = rd; s.rs1 = 5'd2;
    s.asel = 1'b0; s.bsel = 2'b01; s.wre = 1'b1; s.wb = 1'b1; s.ld = 3'b010;
    s.imm = 32'h8;
    return s;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    id_in = rand_slot();
    #3;
    checks++;
    if (act !== '0) begin errs++; $display("FAIL reset_slot: got %h expected 0", act); end
    checks++;
    if (hazard_stall !== 1'b0) begin errs++; $display("FAIL reset_hz: got %b expected 0", hazard_stall); end
`ifdef ID_EX_PERF_EN
    checks++;
    if (bubble_count !== 32'd0) begin errs++; $display("FAIL reset_bub: got %0d expected 0", bubble_count); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    exp_ex = '0;
    exp_bub = '0;
    // First edge after release is a plain load
    id_in = load_x(5'd9);
    tick();
    checks++;
    if (act !== id_in) begin errs++; $display("FAIL post_reset_load: got %h expected %h", act, id_in); end
  endtask

  task automatic test_load_use();
    logic [31:0] bub0;
    id_in = load_x(5'd5);
    tick();
    bub0 = exp_bub;
    id_in = '0;
    id_in.valid = 1'b1; id_in.pc = 32'h104; id_in.rs1 = 5'd5; id_in.rs2 = 5'd1;
    id_in.rd = 5'd6; id_in.bsel = 2'b00; id_in.wre = 1'b1;
    #1;
    checks++;
    if (hazard_stall !== 1'b1) begin errs++; $display("FAIL lu_hz: got %b expected 1", hazard_stall); end
    tick();
    checks++;
    if (ex_valid !== 1'b0) begin errs++; $display("FAIL lu_bubble_valid: got %b expected 0", ex_valid); end
    checks++;
    if (act !== '0) begin errs++; $display("FAIL lu_bubble_slot: got %h expected 0", act); end
    checks++;
    if (hazard_stall !== 1'b0) begin errs++; $display("FAIL lu_hz_drop: got %b expected 0", hazard_stall); end
    tick();
    checks++;
    if (ex_rd_addr !== 5'd6 || ex_valid !== 1'b1) begin
      errs++; $display("FAIL lu_reload: got rd=%0d v=%b expected rd=6 v=1", ex_rd_addr, ex_valid);
    end
`ifdef ID_EX_PERF_EN
    checks++;
    if (bubble_count !== bub0 + 32'd1) begin
      errs++; $display("FAIL lu_bub: got %0d expected %0d", bubble_count, bub0 + 32'd1);
    end
`endif
  endtask

  task automatic test_x0();
    id_in = load_x(5'd0);
    tick();
    id_in = '0;
    id_in.valid = 1'b1; id_in.rs1 = 5'd0; id_in.rs2 = 5'd0; id_in.rd = 5'd7;
    #1;
    checks++;
    if (hazard_stall !== 1'b0) begin errs++; $display("FAIL x0_hz: got %b expected 0", hazard_stall); end
    tick();
    checks++;
    if (act !== exp_ex) begin errs++; $display("FAIL x0_slot: got %h expected %h", act, exp_ex); end
  endtask

  task automatic test_lui_sw();
    id_in = load_x(5'd5);
    tick();
    id_in = '0;
    id_in.valid = 1'b1; id_in.opt = 5'b10001; id_in.rs1 = 5'd5; id_in.rs2 = 5'd7;
    id_in.rd = 5'd5; id_in.bsel = 2'b01; id_in.wre = 1'b1;
    #1;
    checks++;
    if (hazard_stall !== 1'b0) begin errs++; $display("FAIL lui_hz: got %b expected 0", hazard_stall); end
    id_in = '0;
    id_in.valid = 1'b1; id_in.rs1 = 5'd2; id_in.rs2 = 5'd5; id_in.bsel = 2'b01;
    id_in.wram = 2'b10;
    #1;
    checks++;
    if (hazard_stall !== 1'b1) begin errs++; $display("FAIL sw_hz: got %b expected 1", hazard_stall); end
    tick();
    checks++;
    if (act !== exp_ex) begin errs++; $display("FAIL sw_bubble: got %h expected %h", act, exp_ex); end
  endtask

  task automatic test_flush();
    logic [31:0] bub0;
    id_in = load_x(5'd5);
    tick();
    bub0 = exp_bub;
    id_in = '0;
    id_in.valid = 1'b1; id_in.rs1 = 5'd5; id_in.rd = 5'd6;
    ex_flush = 1'b1;
    ex_stall = 1'b1;
    #1;
    checks++;
    if (hazard_stall !== 1'b0) begin errs++; $display("FAIL flush_hz: got %b expected 0", hazard_stall); end
    tick();
    ex_flush = 1'b0;
    ex_stall = 1'b0;
    checks++;
    if (ex_valid !== 1'b0 || act !== '0) begin errs++; $display("FAIL flush_slot: got %h expected 0", act); end
`ifdef ID_EX_PERF_EN
    checks++;
    if (bubble_count !== bub0) begin errs++; $display("FAIL flush_bub: got %0d expected %0d", bubble_count, bub0); end
`endif
  endtask

  task automatic test_stall();
    logic [31:0] pc0;
    id_in = load_x(5'd3);
    id_in.pc = 32'hABC0;
    tick();
    pc0 = ex_pc;
    ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      id_in.pc = 32'h2000 + 32'(i * 4);
      #1;
      checks++;
      if (hazard_stall !== 1'b1) begin errs++; $display("FAIL stall_hz[%0d]: got %b expected 1", i, hazard_stall); end
      tick();
      checks++;
      if (ex_pc !== pc0 || act !== exp_ex) begin
        errs++; $display("FAIL stall_hold[%0d]: got pc %h expected %h", i, ex_pc, pc0);
      end
    end
    ex_stall = 1'b0;
  endtask

  task automatic test_reset_mid();
    id_in = load_x(5'd4);
    tick();
    id_in = '0;
    id_in.valid = 1'b1; id_in.rs1 = 5'd4; id_in.rd = 5'd8;
    #1;
    checks++;
    if (hazard_stall !== 1'b1) begin errs++; $display("FAIL rmid_pre_hz: got %b expected 1", hazard_stall); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (act !== '0) begin errs++; $display("FAIL rmid_slot: got %h expected 0", act); end
    checks++;
    if (hazard_stall !== 1'b0) begin errs++; $display("FAIL rmid_hz: got %b expected 0", hazard_stall); end
`ifdef ID_EX_PERF_EN
    checks++;
    if (bubble_count !== 32'd0) begin errs++; $display("FAIL rmid_bub: got %0d expected 0", bubble_count); end
`endif
    #1;
    rst_n = 1'b1;
    exp_ex = '0;
    exp_bub = '0;
    tick();
    checks++;
    if (act !== id_in) begin errs++; $display("FAIL rmid_first_load: got %h expected %h", act, id_in); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      id_in = rand_slot();
      // Occasionally make the ID instruction depend on the load in EX
      if (exp_ex.valid && $urandom_range(0, 2) == 0) id_in.rs1 = exp_ex.rd;
      ex_flush = ($urandom_range(0, 9) == 0);
      ex_stall = ($urandom_range(0, 6) == 0);
      #1;
      checks++;
      if (hazard_stall !== model_hz()) begin
        errs++; $display("FAIL rnd_hz[%0d]: got %b expected %b", n, hazard_stall, model_hz());
      end
      tick();
      checks++;
      if (act !== exp_ex) begin errs++; $display("FAIL rnd_slot[%0d]: got %h expected %h", n, act, exp_ex); end
`ifdef ID_EX_PERF_EN
      checks++;
      if (bubble_count !== exp_bub) begin
        errs++; $display("FAIL rnd_bub[%0d]: got %0d expected %0d", n, bubble_count, exp_bub);
      end
`endif
    end
    ex_flush = 1'b0;
    ex_stall = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load_use();
    test_x0();
    test_lui_sw();
    test_flush();
    test_stall();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
